pong_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit game data bus in the Ping-Pong design. Player A and player B logic (paddle position or score bytes) each request the bus. The block grants one requester at a time, drives the 2:1 data-select line, and registers the selected byte onto the shared output. It sits between the two player datapaths and the display/collision logic that consumes the bus.

---
 rtl/pong_pkg.sv | 33 +++
 rtl/pong_data_mux.sv | 29 ++
 rtl/pong_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_pong_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Ping-Pong game data bus arbiter.
//   arb_state_t : arbiter state encoding (IDLE / OWN_A / OWN_B)
//   SEL_A/SEL_B : values of the 2:1 data-select line
//   PONG_DW     : width of the shared game data bus
//   tie_winner  : round-robin choice when both requesters ask from IDLE
// ---------------------------------------------------------------------------
package pong_pkg;

    localparam int PONG_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // last = 1 means B was served last, so A wins the tie (and vice versa)
    function automatic arb_state_t tie_winner(input logic last);
        arb_state_t win;
        if (last == 1'b1) begin
            win = OWN_A;
        end else begin
            win = OWN_B;
        end
        return win;
    endfunction

endpackage

// File: rtl/pong_data_mux.sv
// ---------------------------------------------------------------------------
// pong_data_mux
// Combinational 2:1 byte selector for the shared game data bus.
// Ports:
//   sel      in  1        : 0 = data_a, 1 = data_b
//   data_a   in  PONG_DW  : requester A byte
//   data_b   in  PONG_DW  : requester B byte
//   data_out out PONG_DW  : selected byte (registered by the arbiter)
// ---------------------------------------------------------------------------
module pong_data_mux
    import pong_pkg::*;
(
    input  logic               sel,
    input  logic [PONG_DW-1:0] data_a,
    input  logic [PONG_DW-1:0] data_b,
    output logic [PONG_DW-1:0] data_out
);

    // select the byte of the current owner
    always_comb begin
        data_out = data_a;
        if (sel == SEL_B) begin
            data_out = data_b;
        end else begin
            data_out = data_a;
        end
    end

endmodule

// File: rtl/pong_bus_arbiter.sv
// ---------------------------------------------------------------------------
// pong_bus_arbiter
// Two-requester round-robin arbiter for the shared 8-bit game data bus.
// Grants one player datapath at a time, drives the data-select line and
// registers the owner's byte onto the shared output.
//
// Parameters:
//   HOLD_MAX   : max consecutive grant cycles before a forced handover
//                (only with PONG_ARB_TIMEOUT_EN), legal range 2..255
// Ports:
//   clk        in  1 : system clock, rising edge
//   rst_n      in  1 : asynchronous active-low reset
//   req_a      in  1 : requester A wants the bus
//   req_b      in  1 : requester B wants the bus
//   data_a     in  8 : requester A byte
//   data_b     in  8 : requester B byte
//   gnt_a      out 1 : A owns the bus (registered)
//   gnt_b      out 1 : B owns the bus (registered)
//   sel        out 1 : data select, 0 = A, 1 = B (registered)
//   out_data   out 8 : registered byte from the current owner
//   out_valid  out 1 : out_data carries a granted byte
//
// Build option:
//   PONG_ARB_TIMEOUT_EN : when defined, an owner that has held the bus for
//                         HOLD_MAX cycles is forced to hand over if the other
//                         side is requesting. Undefined: no counter is built
//                         and the owner keeps the bus until it lets go.
// ---------------------------------------------------------------------------
module pong_bus_arbiter
    import pong_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               req_b,
    input  logic [PONG_DW-1:0] data_a,
    input  logic [PONG_DW-1:0] data_b,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               sel,
    output logic [PONG_DW-1:0] out_data,
    output logic               out_valid
);

    arb_state_t         state_r;
    arb_state_t         next_state_s;
    logic               entry_s;
    logic               hold_exp_s;
    logic               last_r;
    logic               gnt_a_r;
    logic               gnt_b_r;
    logic               sel_r;
    logic [PONG_DW-1:0] out_data_r;
    logic               out_valid_r;
    logic [PONG_DW-1:0] mux_data_s;

    // Out-of-range HOLD_MAX leaves an empty marker block in the hierarchy.
    if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_max_out_of_range
    end

    pong_data_mux u_mux (
        .sel      (sel_r),
        .data_a   (data_a),
        .data_b   (data_b),
        .data_out (mux_data_s)
    );

`ifdef PONG_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt_r;

    assign hold_exp_s = (hold_cnt_r == HOLD_LAST);

    // consecutive-grant counter: cleared on every new ownership, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (entry_s) begin
            hold_cnt_r <= 8'd0;
        end else if ((state_r != IDLE) && !hold_exp_s) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`else
    assign hold_exp_s = 1'b0;
`endif

    // next owner: keep while requesting, hand straight over otherwise
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_a && req_b) begin
                    next_state_s = tie_winner(last_r);
                end else if (req_a) begin
                    next_state_s = OWN_A;
                end else if (req_b) begin
                    next_state_s = OWN_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN_A: begin
                if (hold_exp_s && req_b) begin
                    next_state_s = OWN_B;
                end else if (req_a) begin
                    next_state_s = OWN_A;
                end else if (req_b) begin
                    next_state_s = OWN_B;
                end else begin
                    next_state_s = IDLE;
                end
            end
            OWN_B: begin
                if (hold_exp_s && req_a) begin
                    next_state_s = OWN_A;
                end else if (req_b) begin
                    next_state_s = OWN_B;
                end else if (req_a) begin
                    next_state_s = OWN_A;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // a new ownership starts whenever the owner changes to a real requester
    assign entry_s = (next_state_s != state_r) && (next_state_s != IDLE);

    // state, grant, select and data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            sel_r       <= SEL_A;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            gnt_a_r <= (next_state_s == OWN_A);
            gnt_b_r <= (next_state_s == OWN_B);
            case (next_state_s)
                OWN_A:   sel_r <= SEL_A;
                OWN_B:   sel_r <= SEL_B;
                default: sel_r <= sel_r;
            endcase
            if (entry_s) begin
                last_r <= (next_state_s == OWN_B);
            end else begin
                last_r <= last_r;
            end
            // data lags the grant by one cycle since sel_r is already registered
            out_valid_r <= (state_r != IDLE);
            if (state_r != IDLE) begin
                out_data_r <= mux_data_s;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign gnt_a     = gnt_a_r;
    assign gnt_b     = gnt_b_r;
    assign sel       = sel_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_pong_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pong_bus_arbiter
// Self-checking bench for pong_bus_arbiter. A behavioural model tracks who
// owns the bus (0 = nobody, 1 = A, 2 = B), the round-robin pointer and the
// hold count, and predicts every output after each rising edge.
// Honours PONG_ARB_TIMEOUT_EN the same way as the design (HOLD_MAX = 4).
// ---------------------------------------------------------------------------
module tb_pong_bus_arbiter;

    localparam int HOLD_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic       req_a;
    logic       req_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       gnt_a;
    logic       gnt_b;
    logic       sel;
    logic [7:0] out_data;
    logic       out_valid;

    int checks;
    int errors;

    // reference model
    int         m_owner;
    bit         m_last;
    int         m_hold;
    bit         m_sel;
    logic [7:0] m_data;
    bit         m_valid;

    pong_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1'b1;
        m_hold  = 0;
        m_sel   = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
    endtask

    // one rising edge of the model, using the inputs present before the edge
    task automatic model_edge();
        int  nxt;
        bit  forced;
        if (m_owner != 0) m_data = m_sel ? data_b : data_a;
        m_valid = (m_owner != 0);
        forced = 1'b0;
`ifdef PONG_ARB_TIMEOUT_EN
        forced = (m_hold == HOLD_MAX - 1);
`endif
        if (m_owner == 0) begin
            if (req_a && req_b) nxt = m_last ? 1 : 2;
            else if (req_a)     nxt = 1;
            else if (req_b)     nxt = 2;
            else                nxt = 0;
        end else begin
            // "mine" is the owner's request, "other" the waiting side
            bit mine  = (m_owner == 1) ? req_a : req_b;
            bit other = (m_owner == 1) ? req_b : req_a;
            int oth_id = 3 - m_owner;
            if (forced && other) nxt = oth_id;
            else if (mine)       nxt = m_owner;
            else if (other)      nxt = oth_id;
            else                 nxt = 0;
        end
        if (nxt != 0 && nxt != m_owner) begin
            m_last = (nxt == 2);
            m_hold = 0;
        end else if (m_owner != 0 && m_hold < HOLD_MAX - 1) begin
            m_hold = m_hold + 1;
        end
        if (nxt == 1) m_sel = 1'b0;
        else if (nxt == 2) m_sel = 1'b1;
        m_owner = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 8'hA5;
        data_b = 8'h5A;
        model_reset();
        repeat (3) step();
        checks++;
        if ({gnt_a, gnt_b, sel, out_valid, out_data} !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset: got ga=%b gb=%b sel=%b v=%b d=%h, want all zero",
                     gnt_a, gnt_b, sel, out_valid, out_data);
        end
        req_a = 1'b0;
        req_b = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req_a  = 1'b1;
        data_a = 8'h3C;
        step();
        checks++;
        if ({gnt_a, gnt_b, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL single_grant: got ga=%b gb=%b v=%b, want 1 0 0", gnt_a, gnt_b, out_valid);
        end
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h3C}) begin
            errors++;
            $display("FAIL single_data: got v=%b d=%h, want 1 3c", out_valid, out_data);
        end
        req_a = 1'b0;
        step();
        step();
        checks++;
        if ({gnt_a, out_valid, out_data} !== {1'b0, 1'b0, 8'h3C}) begin
            errors++;
            $display("FAIL single_release: got ga=%b v=%b d=%h, want 0 0 3c", gnt_a, out_valid, out_data);
        end
    endtask

    task automatic test_tie();
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first: got ga=%b gb=%b, want 1 0", gnt_a, gnt_b);
        end
        req_a = 1'b0;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel} !== 3'b011) begin
            errors++;
            $display("FAIL tie_handover: got ga=%b gb=%b sel=%b, want 0 1 1", gnt_a, gnt_b, sel);
        end
        req_b = 1'b0;
        step();
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b} !== 2'b10) begin
            errors++;
            $display("FAIL tie_second: got ga=%b gb=%b, want 1 0", gnt_a, gnt_b);
        end
    endtask

    task automatic test_handover();
        data_a = 8'h11;
        data_b = 8'h22;
        step();
        checks++;
        if ({gnt_a, sel, out_data} !== {1'b1, 1'b0, 8'h11}) begin
            errors++;
            $display("FAIL handover_a: got ga=%b sel=%b d=%h, want 1 0 11", gnt_a, sel, out_data);
        end
        req_a = 1'b0;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel, out_data} !== {1'b0, 1'b1, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL handover_grant: got ga=%b gb=%b sel=%b d=%h, want 0 1 1 11",
                     gnt_a, gnt_b, sel, out_data);
        end
        step();
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h22}) begin
            errors++;
            $display("FAIL handover_data: got v=%b d=%h, want 1 22", out_valid, out_data);
        end
        req_b = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        bit want_a;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
`ifdef PONG_ARB_TIMEOUT_EN
            want_a = ((i / HOLD_MAX) % 2) == 0;
`else
            want_a = 1'b1;
`endif
            checks++;
            if ({gnt_a, gnt_b} !== {want_a, ~want_a}) begin
                errors++;
                $display("FAIL timeout_seq[%0d]: got ga=%b gb=%b, want %b %b",
                         i, gnt_a, gnt_b, want_a, ~want_a);
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_a  = ($urandom_range(0, 3) != 0);
            req_b  = ($urandom_range(0, 3) != 0);
            data_a = 8'($urandom);
            data_b = 8'($urandom);
            step();
            checks++;
            if ({gnt_a, gnt_b, sel, out_valid, out_data} !==
                {(m_owner == 1), (m_owner == 2), m_sel, m_valid, m_data}) begin
                errors++;
                $display("FAIL random[%0d]: got ga=%b gb=%b sel=%b v=%b d=%h, want %b %b %b %b %h",
                         i, gnt_a, gnt_b, sel, out_valid, out_data,
                         (m_owner == 1), (m_owner == 2), m_sel, m_valid, m_data);
            end
        end
    endtask

    task automatic test_mid_reset();
        req_a = 1'b0;
        req_b = 1'b1;
        step();
        step();
        checks++;
        if ({gnt_b, out_valid} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_setup: got gb=%b v=%b, want 1 1", gnt_b, out_valid);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt_a, gnt_b, sel, out_valid, out_data} !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midrst_clear: got ga=%b gb=%b sel=%b v=%b d=%h, want all zero",
                     gnt_a, gnt_b, sel, out_valid, out_data);
        end
        req_a = 1'b1;
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if ({gnt_a, gnt_b, sel} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_after: got ga=%b gb=%b sel=%b, want 1 0 0", gnt_a, gnt_b, sel);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req_a  = 1'b0;
        req_b  = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_handover();
        test_timeout();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
